// File: rtl/jtframe_68kbus_pkg.sv
// Shared definitions for the 68000 bus arbiter: FSM state encoding, owner index
// width and the round-robin pointer advance.
package jtframe_68kbus_pkg;

  localparam int OWNER_W = 3;
  localparam int MAX_DEV = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    WAITAS = 3'd2,
    GRANT  = 3'd3,
    OWNED  = 3'd4,
    REL    = 3'd5
  } state_t;

  // Start position for the next arbitration round: the device after idx, wrapping at ndev.
  function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] idx, input int ndev);
    logic [OWNER_W-1:0] nxt;
    if (int'(idx) >= ndev - 1) begin
      nxt = 3'd0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/jtframe_rrpick.sv
// Combinational round-robin picker: returns the first requesting device at or
// after the start pointer, wrapping modulo NDEV.
module jtframe_rrpick
  import jtframe_68kbus_pkg::*;
#(
  parameter int NDEV = 2
)(
  input  logic [NDEV-1:0]    req,
  input  logic [OWNER_W-1:0] start,
  output logic               found,
  output logic [OWNER_W-1:0] idx
);

  localparam int PW = OWNER_W + 1;

  logic [PW-1:0] dist_s;
  logic [PW-1:0] best_s;
  logic          better_s;

  // Pick the requester with the smallest wrapped distance from the start pointer.
  always_comb begin
    dist_s   = {PW{1'b0}};
    best_s   = PW'(NDEV);
    better_s = 1'b0;
    idx      = {OWNER_W{1'b0}};
    for (int i = 0; i < NDEV; i++) begin
      dist_s   = (OWNER_W'(i) >= start) ? ({1'b0, OWNER_W'(i)} - {1'b0, start})
                                        : ({1'b0, OWNER_W'(i)} + PW'(NDEV) - {1'b0, start});
      better_s = req[i] && (dist_s < best_s);
      best_s   = better_s ? dist_s : best_s;
      idx      = better_s ? OWNER_W'(i) : idx;
    end
    found = |req;
  end

endmodule

// File: rtl/jtframe_68kbusarb.sv
// 68000 bus arbiter, grant side of BR/BG/BGACK: round-robin grant to one of
// NDEV external masters while holding the CPU off the bus.
module jtframe_68kbusarb
  import jtframe_68kbus_pkg::*;
#(
  parameter int NDEV  = 2,
  parameter int TOUTW = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               cpu_ASn,
  input  logic               cpu_DTACKn,
  output logic               cpu_halt,
  input  logic [NDEV-1:0]    dev_BRn,
  output logic [NDEV-1:0]    dev_BGn,
  input  logic               dev_BGACKn,
  output logic [OWNER_W-1:0] owner,
  output logic               busy,
  output logic               tout
);

  state_t             state_r;
  logic [NDEV-1:0]    br_sync_r;
  logic               ack_sync_r;
  logic [OWNER_W-1:0] rr_r;
  logic [TOUTW-1:0]   cnt_r;

  logic [NDEV-1:0]    req_s;
  logic [NDEV-1:0]    gnt_n_s;
  logic               own_br_n_s;
  logic [TOUTW-1:0]   cnt_inc_s;
  logic               cnt_full_s;
  logic               pick_found_s;
  logic [OWNER_W-1:0] pick_idx_s;

  jtframe_rrpick #(.NDEV(NDEV)) u_pick (
    .req   (req_s),
    .start (rr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Owner-indexed views of the synced requests, the grant pattern and the timeout count.
  always_comb begin
    req_s      = ~br_sync_r;
    own_br_n_s = 1'b1;
    gnt_n_s    = {NDEV{1'b1}};
    for (int i = 0; i < NDEV; i++) begin
      own_br_n_s = (owner == OWNER_W'(i)) ? br_sync_r[i] : own_br_n_s;
      gnt_n_s[i] = (owner != OWNER_W'(i));
    end
    cnt_inc_s  = cnt_r + TOUTW'(1'b1);
    cnt_full_s = &cnt_inc_s;
  end

  // Input synchroniser and arbitration FSM; every output is a register of this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      br_sync_r  <= {NDEV{1'b1}};
      ack_sync_r <= 1'b1;
      rr_r       <= {OWNER_W{1'b0}};
      cnt_r      <= {TOUTW{1'b0}};
      dev_BGn    <= {NDEV{1'b1}};
      cpu_halt   <= 1'b0;
      owner      <= {OWNER_W{1'b0}};
      busy       <= 1'b0;
      tout       <= 1'b0;
    end else if (cen) begin
      br_sync_r  <= dev_BRn;
      ack_sync_r <= dev_BGACKn;
      tout       <= 1'b0;
      case (state_r)
        IDLE: begin
          cpu_halt <= 1'b0;
          if (|req_s) state_r <= ARB;
        end
        ARB: begin
          if (pick_found_s) begin
            owner    <= pick_idx_s;
            cpu_halt <= 1'b1;
            state_r  <= WAITAS;
          end else begin
            cpu_halt <= 1'b0;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        WAITAS: begin
          cpu_halt <= 1'b1;
          // A bus cycle still in flight must complete before the bus changes hands
          if (cpu_ASn && cpu_DTACKn) begin
            dev_BGn <= gnt_n_s;
            busy    <= 1'b1;
            cnt_r   <= {TOUTW{1'b0}};
            state_r <= GRANT;
          end
        end
        GRANT: begin
          if (!ack_sync_r) begin
            dev_BGn <= {NDEV{1'b1}};
            state_r <= OWNED;
          end else if (own_br_n_s) begin
            dev_BGn <= {NDEV{1'b1}};
            state_r <= REL;
          end else begin
            cnt_r <= cnt_inc_s;
            if (cnt_full_s) begin
              tout    <= 1'b1;
              dev_BGn <= {NDEV{1'b1}};
              state_r <= REL;
            end
          end
        end
        OWNED: begin
          cpu_halt <= 1'b1;
          busy     <= 1'b1;
          if (ack_sync_r) state_r <= REL;
        end
        REL: begin
          rr_r <= rr_next(owner, NDEV);
          busy <= 1'b0;
          // Back-to-back requests keep the CPU frozen across the next arbitration
          if ((|req_s) && ack_sync_r) begin
            cpu_halt <= 1'b1;
            state_r  <= ARB;
          end else begin
            cpu_halt <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          dev_BGn  <= {NDEV{1'b1}};
          cpu_halt <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
